imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: fills the 32-bit word-addressed instruction memory from a byte stream, for example from a UART receiver.
- Sits between the serial host link and the memory write port.
- Holds the single-cycle core in reset until a complete program has been written.
- Replaces the hard-coded initial program with a runtime load.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory; the maximum loadable program length.
- ADDR_W, 8, width of the word address driven to the memory (matches the memory's 8-bit word index).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load when in IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte accepted on a cycle where in_valid and in_ready are both high.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_waddr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  high in LEN, DATA and WRITE.
- done  output  1  high in DONE.
- err  output  1  high in ERR.
- cpu_rst_n  output  1  core reset; low unless in DONE.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - state = IDLE;
  - in_ready, mem_we, busy, done and err = 0;
  - mem_waddr and mem_wdata = 0;
  - cpu_rst_n = 0;
  - byte counter, word counter and length register = 0.
- Reset asserted mid-load aborts the load immediately. Memory contents are unspecified; cpu_rst_n stays low.
- Frame format on the byte stream:
  - byte 0 = N, the word count;
  - then 4N bytes, little-endian per word (first byte goes to bits [7:0]).
- IDLE:
  - in_ready = 0.
  - On start -> LEN.
- LEN:
  - in_ready = 1.
  - On accept: N = 0 -> DONE with no writes.
  - N > DEPTH -> ERR.
  - Otherwise latch N, clear counters -> DATA.
- DATA:
  - in_ready = 1.
  - Each accept shifts the byte into lane byte_cnt (0..3).
  - On the 4th accept -> WRITE.
- WRITE (exactly one cycle):
  - mem_we = 1, mem_waddr = word_cnt, mem_wdata = assembled word; in_ready = 0.
  - Next cycle: word_cnt increments. If word_cnt+1 == N -> DONE, else -> DATA.
  - Latency: the write strobe appears the cycle after the 4th byte of a word is accepted.
- DONE:
  - done = 1, cpu_rst_n = 1, in_ready = 0.
  - On start -> LEN, and cpu_rst_n drops to 0 the same cycle.
- ERR:
  - err = 1, cpu_rst_n = 0, in_ready = 0.
  - On start -> LEN.
- start is ignored in LEN, DATA and WRITE.
- in_valid while in_ready = 0: the byte is not consumed; the source holds it.
- Addresses never exceed DEPTH-1. word_cnt is ADDR_W bits and cannot wrap, because N <= DEPTH.
- All outputs are registered; no combinational path from in_valid to in_ready.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word, state CSUM accepts one trailing byte. This holds for N = 0 too: LEN goes to CSUM.
  - The byte must equal the XOR of all 4N data bytes (0x00 when N = 0).
  - Match -> DONE. Mismatch -> ERR; words already written stay written, but the core remains in reset.
- When undefined: there is no CSUM state; the last WRITE goes directly to DONE.

Decomposition:
- Shared package imem_pkg holds:
  - IMEM_DEPTH = 64, IMEM_ADDR_W = 8, INSTR_W = 32;
  - the state typedef (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR).
- The instruction memory write port and this loader both use the package.
- One natural sub-module: byte_packer.
  - Function: 2-bit lane counter plus 32-bit shift/assemble register, with clear and load inputs.
  - Outputs: word_full and the assembled word.

Test Plan:
- Reset, then start, then stream 0x02, 33,70,00,00, 93,00,10,00 -> writes 0x00007033 @0 and 0x00100093 @1. mem_we is high for exactly 2 cycles, then done = 1 and cpu_rst_n = 1.
- Start, then N = 0x00 -> DONE with no mem_we and cpu_rst_n = 1. With IMEM_LOADER_CHECKSUM_EN, a trailing byte 0x00 is required.
- Start, then N = 0x41 (65) -> err = 1, no writes, cpu_rst_n = 0. A second start plus a valid frame recovers to DONE.
- Random in_valid gaps and start pulses during DATA -> identical memory writes. start is ignored and in_ready is low on every WRITE cycle.
- Assert rst_n low after 6 data bytes of a 3-word load -> all outputs at reset values asynchronously. Next start plus a full frame loads correctly.
- With IMEM_LOADER_CHECKSUM_EN, load 1 word 0x00200113 with checksum 0x32 -> DONE. Same load with checksum 0x33 -> ERR and cpu_rst_n = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory sizes and loader state encoding
package imem_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles four little-endian bytes into one instruction word
module imem_loader_byte_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [7:0]         data,
  output logic               word_full,
  output logic [INSTR_W-1:0] word
);

  logic [1:0] lane;

  // Flags the load that completes a word so the loader can strobe the write next cycle.
  assign word_full = load && (lane == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= 2'd0;
      word <= '0;
    end else if (clear) begin
      lane <= 2'd0;
      word <= '0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= data;
      lane                      <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads instruction memory from a length-prefixed byte stream, holding the core in reset
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cpu_rst_n
);

  localparam logic [7:0] DEPTH_N = 8'(DEPTH);

  loader_state_t     state;
  logic [7:0]        len;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] next_cnt;
  logic              accept;
  logic              pk_clear;
  logic              pk_load;
  logic              pk_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept   = in_valid && in_ready;
  assign pk_clear = (state == LEN) && accept;
  assign pk_load  = (state == DATA) && accept;
  assign next_cnt = word_cnt + ADDR_W'(1);

  // The packer register is the write-data register; it is only sampled while mem_we is high.
  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .load      (pk_load),
    .data      (in_data),
    .word_full (pk_full),
    .word      (mem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b0;
      len       <= '0;
      word_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= LEN;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
          end
        end
        LEN: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
            if (in_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CSUM;
`else
              state     <= DONE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
`endif
            end else if (in_data > DEPTH_N) begin
              state    <= ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              state    <= DATA;
              len      <= in_data;
              word_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (pk_full) begin
              state     <= WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_waddr <= word_cnt;
            end
          end
        end
        WRITE: begin
          word_cnt <= next_cnt;
          if (next_cnt == ADDR_W'(len)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CSUM;
            in_ready <= 1'b1;
`else
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_rst_n <= 1'b1;
`endif
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (vector table, random frames, reset abort)
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst_n (cpu_rst_n)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] frame_w [64];
  logic [39:0] wlog [$];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_flip = 8'd0;
`endif

  typedef struct {
    logic [7:0]  n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Every write strobe is logged; in_ready must be low and the address in range on each one.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wlog.push_back({mem_waddr, mem_wdata});
      check("write_in_ready", 64'(in_ready), 64'd0);
      check("write_addr_range", 64'(mem_waddr < 8'd64), 64'd1);
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    bit to;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        start = ($urandom_range(0, 2) == 0);
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t  = 0;
    to = 1'b0;
    @(negedge clk);
    while (in_ready !== 1'b1 && !to) begin
      t++;
      if (t > 50) to = 1'b1;
      else @(negedge clk);
    end
    if (!to) @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 8'($urandom);
    if (to) check("accept_timeout", 64'(to), 64'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] n, input bit gaps,
                           input bit exp_done, input bit exp_err, input int exp_writes);
    int t;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
`endif
    wlog.delete();
    pulse_start();
    send_byte(n, 1'b0);
    if (n <= 8'd64) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int k = 0; k < 4; k++) begin
          send_byte(frame_w[i][8*k +: 8], gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
          x = x ^ frame_w[i][8*k +: 8];
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x ^ csum_flip, 1'b0);
`endif
    end
    t = 0;
    @(negedge clk);
    while (!(done | err) && t < 100) begin
      t++;
      @(negedge clk);
    end
    check({tag, " end_timeout"}, 64'(t >= 100), 64'd0);
    check({tag, " done"}, 64'(done), 64'(exp_done));
    check({tag, " err"}, 64'(err), 64'(exp_err));
    check({tag, " cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_done));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " in_ready"}, 64'(in_ready), 64'd0);
    check({tag, " nwrites"}, 64'(wlog.size()), 64'(exp_writes));
    for (int i = 0; i < wlog.size() && i < exp_writes; i++)
      check({tag, " write"}, 64'(wlog[i]), 64'({8'(i), frame_w[i]}));
  endtask

  task automatic load_words(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < 64; i++) frame_w[i] = $urandom;
    frame_w[0] = w0;
    frame_w[1] = w1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rn;
    bit         ok;

    vecs[0] = '{8'h02, 32'h00007033, 32'h00100093, 1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{8'h00, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h41, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{8'h02, 32'h00007033, 32'h00100093, 1'b1, 1'b1, 1'b0, 2};
    vecs[4] = '{8'h01, 32'h00200113, 32'h0,        1'b1, 1'b1, 1'b0, 1};
    vecs[5] = '{8'h40, 32'hdeadbeef, 32'h12345678, 1'b0, 1'b1, 1'b0, 64};
    vecs[6] = '{8'hff, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({in_ready, mem_we, busy, done, err, cpu_rst_n, mem_waddr, mem_wdata}), 64'd0);
    #2 rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      load_words(vecs[v].w0, vecs[v].w1);
      run_frame($sformatf("vec%0d", v), vecs[v].n, vecs[v].gaps,
                vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_writes);
    end

    // Random frames judged by the framing rule: N <= 64 loads N words, anything larger errors out.
    for (int r = 0; r < 8; r++) begin
      rn = 8'($urandom_range(0, 70));
      ok = (rn <= 8'd64);
      load_words($urandom, $urandom);
      run_frame($sformatf("rand%0d", r), rn, 1'b1, ok, !ok, ok ? int'(rn) : 0);
    end

    // Reset mid-load: abort after 6 data bytes of a 3-word frame.
    load_words(32'h11223344, 32'h55667788);
    pulse_start();
    send_byte(8'h03, 1'b0);
    for (int b = 0; b < 6; b++) send_byte(frame_w[b / 4][8*(b % 4) +: 8], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 64'({in_ready, mem_we, busy, done, err, cpu_rst_n, mem_waddr, mem_wdata}), 64'd0);
    #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 64'({in_ready, busy, done, err, cpu_rst_n}), 64'd0);
    load_words(vecs[0].w0, vecs[0].w1);
    run_frame("post_reset", vecs[0].n, 1'b0, 1'b1, 1'b0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    load_words(32'h00200113, 32'h0);
    csum_flip = 8'h00;
    run_frame("csum_ok", 8'h01, 1'b0, 1'b1, 1'b0, 1);
    csum_flip = 8'h01;
    run_frame("csum_bad", 8'h01, 1'b0, 1'b0, 1'b1, 1);
    csum_flip = 8'h00;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
